soc_reset_sequencer: RTL and testbench

SOC_RESET_SEQUENCER -- requirements
Module: soc_reset_sequencer

---
 rtl/cvw.sv | 20 ++
 rtl/reset_sync_n.sv | 23 ++
 rtl/soc_reset_sequencer.sv | 136 +++++++++++++
 tb/tb_soc_reset_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cvw.sv
// Shared definitions for the reset sequencer: FSM state and reset-cause encodings,
// plus the width of the sequencing timer.
package cvw;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_EXT = 2'b00,
        CAUSE_SW  = 2'b01,
        CAUSE_WDT = 2'b10
    } rst_cause_e;

    // Wide enough for MIN_ASSERT and STEP up to 255.
    localparam int unsigned SEQ_CNT_W = 8;

endpackage

// File: rtl/reset_sync_n.sv
// Reset deassertion synchronizer: output asserts asynchronously with reset and
// deasserts DEPTH rising edges of clk after reset is released.
module reset_sync_n #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    output logic rst_sync_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], 1'b0};
        end
    end

    assign rst_sync_o = sync_q[DEPTH-1];

endmodule

// File: rtl/soc_reset_sequencer.sv
// Staged release of NCH reset domains after an external, software or watchdog reset.
// Build option: define RESET_SEQ_WDT_EN to include the RUN-state watchdog.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_HOLD    | all domains in reset, counting MIN_ASSERT cycles
// ST_RELEASE | releasing domain idx_q after every STEP cycles
// ST_RUN     | all domains released, watchdog may run
module soc_reset_sequencer
    import cvw::*;
#(
    parameter int unsigned NCH         = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_ASSERT  = 16,
    parameter int unsigned STEP        = 8,
    parameter int unsigned WDT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SwResetReq,
    input  logic             WdtEn,
    input  logic             WdtKick,
    input  logic [WDT_W-1:0] WdtLimit,
    output logic [NCH-1:0]   ResetOut,
    output logic             ResetDone,
    output logic [1:0]       ResetCause
);

    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NCH - 1);
    localparam logic [SEQ_CNT_W-1:0] HOLD_LAST = SEQ_CNT_W'(MIN_ASSERT - 1);
    localparam logic [SEQ_CNT_W-1:0] STEP_LAST = SEQ_CNT_W'(STEP - 1);

    rst_state_e           state_q;
    rst_cause_e           cause_q;
    logic [SEQ_CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NCH-1:0]       rst_out_q;
    logic                 done_q;
    logic                 rst_sync;
    logic                 wdt_expire;

    reset_sync_n #(
        .DEPTH (SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .reset      (reset),
        .rst_sync_o (rst_sync)
    );

`ifdef RESET_SEQ_WDT_EN
    logic [WDT_W-1:0] wdt_q;
    logic             wdt_run;

    assign wdt_run    = (state_q == ST_RUN) && WdtEn && !rst_sync;
    assign wdt_expire = wdt_run && !WdtKick && (WdtLimit != '0) && (wdt_q == WdtLimit);

    // Any way out of RUN (timeout, software request, reset) leaves the count at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_q <= '0;
        end else if (rst_sync || (state_q != ST_RUN) || wdt_expire || SwResetReq) begin
            wdt_q <= '0;
        end else if (WdtEn) begin
            wdt_q <= WdtKick ? '0 : wdt_q + 1'b1;
        end
    end
`else
    logic unused_wdt;

    assign wdt_expire = 1'b0;
    assign unused_wdt = ^{WdtEn, WdtKick, WdtLimit};
`endif

    // While the synchronizer is still asserted every register keeps its reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HOLD;
            cause_q   <= CAUSE_EXT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
        end else if (!rst_sync) begin
            if (wdt_expire || SwResetReq) begin
                state_q   <= ST_HOLD;
                cause_q   <= wdt_expire ? CAUSE_WDT : CAUSE_SW;
                cnt_q     <= '0;
                idx_q     <= '0;
                rst_out_q <= '1;
                done_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (cnt_q == HOLD_LAST) begin
                            state_q <= ST_RELEASE;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt_q == STEP_LAST) begin
                            cnt_q            <= '0;
                            rst_out_q[idx_q] <= 1'b0;
                            if (idx_q == LAST_IDX) begin
                                state_q <= ST_RUN;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        state_q <= ST_RUN;
                    end
                    default: begin
                        state_q   <= ST_HOLD;
                        cnt_q     <= '0;
                        idx_q     <= '0;
                        rst_out_q <= '1;
                        done_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ResetOut   = rst_out_q;
    assign ResetDone  = done_q;
    assign ResetCause = cause_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Bench for soc_reset_sequencer: elapsed-time reference model against directed and random stimulus.
module tb_soc_reset_sequencer;

    localparam int NCH    = 3;
    localparam int SYNC   = 2;
    localparam int MIN_A  = 4;
    localparam int STEP   = 2;
    localparam int WDT_W  = 16;
    localparam int DONE_T = MIN_A + NCH * STEP;

`ifdef RESET_SEQ_WDT_EN
    localparam bit WDT_BUILT = 1'b1;
`else
    localparam bit WDT_BUILT = 1'b0;
`endif

    logic             clk        = 1'b0;
    logic             reset      = 1'b0;
    logic             SwResetReq = 1'b0;
    logic             WdtEn      = 1'b0;
    logic             WdtKick    = 1'b0;
    logic [WDT_W-1:0] WdtLimit   = '0;
    logic [NCH-1:0]   ResetOut;
    logic             ResetDone;
    logic [1:0]       ResetCause;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: m_t = clock edges since HOLD was (effectively) entered.
    int m_t;
    int m_cause;
    int m_wdt;
    int m_sync;

    soc_reset_sequencer #(
        .NCH         (NCH),
        .SYNC_STAGES (SYNC),
        .MIN_ASSERT  (MIN_A),
        .STEP        (STEP),
        .WDT_W       (WDT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .SwResetReq (SwResetReq),
        .WdtEn      (WdtEn),
        .WdtKick    (WdtKick),
        .WdtLimit   (WdtLimit),
        .ResetOut   (ResetOut),
        .ResetDone  (ResetDone),
        .ResetCause (ResetCause)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [NCH-1:0] exp_out();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_t < MIN_A + (i + 1) * STEP);
        return v;
    endfunction

    function automatic logic exp_done();
        return (m_t >= DONE_T);
    endfunction

    task automatic model_reset();
        m_t     = 0;
        m_cause = 0;
        m_wdt   = 0;
        m_sync  = SYNC;
    endtask

    task automatic model_edge(input bit sw, input bit en, input bit kick, input int lim);
        bit running;
        bit expire;
        if (m_sync > 0) begin
            m_sync--;
            return;
        end
        running = (m_t >= DONE_T);
        expire  = WDT_BUILT && running && en && !kick && (lim != 0) && (m_wdt == lim);
        if (expire) begin
            m_t = 0; m_cause = 2; m_wdt = 0;
        end else if (sw) begin
            m_t = 0; m_cause = 1; m_wdt = 0;
        end else begin
            if (running && en) m_wdt = kick ? 0 : (m_wdt + 1) % 65536;
            if (m_t < 1000000) m_t++;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"},   8'(ResetOut),   8'(exp_out()));
        chk({tag, ".done"},  8'(ResetDone),  8'(exp_done()));
        chk({tag, ".cause"}, 8'(ResetCause), 8'(m_cause));
    endtask

    task automatic step(input bit sw, input bit en, input bit kick, input int lim, input string tag);
        SwResetReq = sw;
        WdtEn      = en;
        WdtKick    = kick;
        WdtLimit   = WDT_W'(lim);
        @(posedge clk);
        model_edge(sw, en, kick, lim);
        #1;
        check_all(tag);
    endtask

    // Entered one time unit after a rising edge; reset rises between edges.
    task automatic pulse_reset(input int hold);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        repeat (hold) @(posedge clk);
        #1;
        check_all("rst_held");
        reset = 1'b0;
    endtask

    initial begin
        bit en_r;
        int lim_r;

        #1 reset = 1'b1;
        model_reset();
        #1;
        check_all("por");
        repeat (2) @(posedge clk);
        #1;
        check_all("por_held");
        reset = 1'b0;

        for (int k = 1; k <= 14; k++) begin
            step(0, 0, 0, 0, "ext_seq");
            if (k == 7)  chk("ext_k7",  8'(ResetOut), 8'h07);
            if (k == 8)  chk("ext_k8",  8'(ResetOut), 8'h06);
            if (k == 10) chk("ext_k10", 8'(ResetOut), 8'h04);
            if (k == 12) begin
                chk("ext_k12", 8'(ResetOut), 8'h00);
                chk("ext_done", 8'(ResetDone), 8'h01);
            end
        end

        step(1, 0, 0, 0, "sw_run");
        chk("sw_run.out",   8'(ResetOut),   8'h07);
        chk("sw_run.cause", 8'(ResetCause), 8'h01);
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 0, "sw_seq");
            if (k == 6)  chk("sw_k6",  8'(ResetOut), 8'h06);
            if (k == 10) chk("sw_k10", 8'(ResetDone), 8'h01);
        end

        for (int i = 0; i < 30 && exp_out() != 3'b110; i++) step(0, 0, 0, 0, "to_110");
        step(1, 0, 0, 0, "sw_rel");
        chk("sw_rel.out", 8'(ResetOut), 8'h07);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, "sw_held");
        chk("sw_held.out", 8'(ResetOut), 8'h07);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 0, "sw_restart");

        for (int k = 0; k < 12; k++) step(0, 1, 0, 5, "wdt_nokick");
        for (int k = 0; k < 14; k++) step(0, 0, 0, 0, "wdt_recover");
        for (int k = 0; k < 1000; k++) step(0, 1, (k % 4) == 3, 5, "wdt_kick");
        for (int k = 0; k < 1000; k++) step(0, 1, 0, 0, "wdt_lim0");

        step(0, 1, 1, 3, "coinc_kick");
        for (int i = 0; i < 20 && m_wdt != 3; i++) step(0, 1, 0, 3, "coinc_run");
        step(1, 1, 0, 3, "coinc");
        chk("coinc.out", 8'(ResetOut), 8'h07);

        for (int i = 0; i < 30 && exp_out() != 3'b100; i++) step(0, 0, 0, 0, "to_100");
        pulse_reset(2);
        for (int k = 0; k < 14; k++) step(0, 0, 0, 0, "post_rst");

        en_r  = 1'b1;
        lim_r = 4;
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) begin
                en_r  = ($urandom_range(0, 3) != 0);
                lim_r = $urandom_range(0, 9);
            end
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset(1 + $urandom_range(0, 2));
            end else begin
                step($urandom_range(0, 39) == 0, en_r, $urandom_range(0, 3) == 0, lim_r, "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
